// File: rtl/sargantana_icache_pkg.sv
// Shared types and defaults for the icache iFill interface and its far-end responder.
package sargantana_icache_pkg;

   localparam int unsigned LINE_WIDTH          = 128;
   localparam int unsigned MEM_DATA_WIDTH      = 32;
   localparam int unsigned PADDR_WIDTH         = 40;
   localparam int unsigned INV_FIFO_DEPTH      = 4;
   localparam int unsigned ICACHE_N_WAY        = 4;
   localparam int unsigned ICACHE_WAY_WIDTH    = $clog2(ICACHE_N_WAY);
   localparam int unsigned ICACHE_OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);

   // Line-fill request issued by the icache.
   typedef struct packed {
      logic                        valid;
      logic [PADDR_WIDTH-1:0]      paddr;
      logic [ICACHE_WAY_WIDTH-1:0] way;
   } ifill_req_o_t;

   // Invalidation sideband carried on the fill response channel.
   typedef struct packed {
      logic                   valid;
      logic [PADDR_WIDTH-1:0] paddr;
   } ifill_inv_t;

   // Fill response returned to the icache; ack is not produced by this responder.
   typedef struct packed {
      logic                  valid;
      logic                  ack;
      logic [LINE_WIDTH-1:0] data;
      ifill_inv_t            inv;
   } ifill_resp_i_t;

   // Responder FSM states.
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_REQ  = 2'd1,
      S_MEM_DATA = 2'd2,
      S_RESP     = 2'd3
   } ifill_rsp_state_t;

   // One pending L2 invalidation.
   typedef struct packed {
      logic [PADDR_WIDTH-1:0] paddr;
   } inv_entry_t;

   // Clear the byte-offset bits so the address points at the start of the line.
   function automatic logic [PADDR_WIDTH-1:0] line_align(input logic [PADDR_WIDTH-1:0] paddr);
      line_align = {paddr[PADDR_WIDTH-1:ICACHE_OFFSET_WIDTH], {ICACHE_OFFSET_WIDTH{1'b0}}};
   endfunction

endpackage

// File: rtl/sargantana_ifill_inv_fifo.sv
// Small synchronous FIFO buffering L2 invalidations until the responder is idle.
// Pushes while full are dropped; push and pop in the same cycle both take effect.
module sargantana_ifill_inv_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 40
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents are only observed while the FIFO is non-empty.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/sargantana_icache_ifill_responder.sv
// Far end of the icache iFill interface: fetches a line over a narrow memory port,
// returns it as a single response beat, and injects buffered L2 invalidations into
// the same response channel whenever no fill is in progress.
module sargantana_icache_ifill_responder #(
   parameter int unsigned LINE_WIDTH     = sargantana_icache_pkg::LINE_WIDTH,
   parameter int unsigned MEM_DATA_WIDTH = sargantana_icache_pkg::MEM_DATA_WIDTH,
   parameter int unsigned PADDR_WIDTH    = sargantana_icache_pkg::PADDR_WIDTH,
   parameter int unsigned INV_FIFO_DEPTH = sargantana_icache_pkg::INV_FIFO_DEPTH
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  sargantana_icache_pkg::ifill_req_o_t  ifill_req_i,
   output sargantana_icache_pkg::ifill_resp_i_t ifill_resp_o,
   output logic                                 mem_req_valid_o,
   input  logic                                 mem_req_ready_i,
   output logic [PADDR_WIDTH-1:0]               mem_req_addr_o,
   input  logic                                 mem_resp_valid_i,
   input  logic [MEM_DATA_WIDTH-1:0]            mem_resp_data_i,
   input  logic                                 inv_valid_i,
   input  logic [PADDR_WIDTH-1:0]               inv_paddr_i,
   output logic                                 inv_ready_o,
   output logic                                 busy_o
);

   import sargantana_icache_pkg::*;

   localparam int unsigned N_BEATS = LINE_WIDTH / MEM_DATA_WIDTH;
   localparam int unsigned CNT_W   = $clog2(N_BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

   ifill_rsp_state_t        state_q;
   ifill_rsp_state_t        state_d;
   logic [PADDR_WIDTH-1:0]  addr_q;
   logic [PADDR_WIDTH-1:0]  addr_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [LINE_WIDTH-1:0]   line_q;
   logic                    beat_fire;

   inv_entry_t              fifo_wdata;
   inv_entry_t              fifo_rdata;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;

   // The way is tracked by the icache itself; the responder does not need it.
   logic                    req_way_unused;
   assign req_way_unused = ^ifill_req_i.way;

   assign fifo_wdata.paddr = inv_paddr_i;
   assign fifo_push        = inv_valid_i & inv_ready_o;
   assign inv_ready_o      = ~fifo_full;
   assign busy_o           = (state_q != S_IDLE);
   assign mem_req_addr_o   = addr_q;
   assign beat_fire        = (state_q == S_MEM_DATA) & mem_resp_valid_i;

   sargantana_ifill_inv_fifo #(
      .DEPTH (INV_FIFO_DEPTH),
      .WIDTH ($bits(inv_entry_t))
   ) u_inv_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // FSM state and latched line address.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Beat counter and line assembly; beats outside MEM_DATA are ignored.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else if (beat_fire) begin
         line_q[cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_resp_data_i;
         cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
      end
   end

   // Next-state and response generation; pending invalidations win over new fills in IDLE.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      fifo_pop        = 1'b0;
      mem_req_valid_o = 1'b0;
      ifill_resp_o    = '0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop                 = 1'b1;
               ifill_resp_o.valid       = 1'b1;
               ifill_resp_o.inv.valid   = 1'b1;
               ifill_resp_o.inv.paddr   = fifo_rdata.paddr;
            end else if (ifill_req_i.valid) begin
               addr_d  = line_align(ifill_req_i.paddr);
               state_d = S_MEM_REQ;
            end
         end
         S_MEM_REQ: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) begin
               state_d = S_MEM_DATA;
            end
         end
         S_MEM_DATA: begin
            if (mem_resp_valid_i && (cnt_q == LAST_BEAT)) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            ifill_resp_o.valid = 1'b1;
            ifill_resp_o.data  = line_q;
            state_d            = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sargantana_icache_ifill_responder.sv
// Directed bench for the iFill responder: fills, backpressure, invalidation injection,
// FIFO overflow, held requests and mid-fill reset.
module tb_sargantana_icache_ifill_responder;

   import sargantana_icache_pkg::*;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   ifill_req_o_t  ifill_req_i;
   ifill_resp_i_t ifill_resp_o;
   logic          mem_req_valid_o;
   logic          mem_req_ready_i;
   logic [39:0]   mem_req_addr_o;
   logic          mem_resp_valid_i;
   logic [31:0]   mem_resp_data_i;
   logic          inv_valid_i;
   logic [39:0]   inv_paddr_i;
   logic          inv_ready_o;
   logic          busy_o;

   int            checks = 0;
   int            errors = 0;
   int            fill_cnt = 0;
   int            memreq_cnt = 0;
   logic [127:0]  fill_data = '0;
   logic [39:0]   inv_q[$];
   int            prev_fill;
   int            prev_memreq;

   sargantana_icache_ifill_responder #(
      .LINE_WIDTH     (128),
      .MEM_DATA_WIDTH (32),
      .PADDR_WIDTH    (40),
      .INV_FIFO_DEPTH (4)
   ) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .ifill_req_i      (ifill_req_i),
      .ifill_resp_o     (ifill_resp_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_data_i  (mem_resp_data_i),
      .inv_valid_i      (inv_valid_i),
      .inv_paddr_i      (inv_paddr_i),
      .inv_ready_o      (inv_ready_o),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Record every response and every accepted memory request mid-cycle.
   always @(negedge clk_i) begin
      if (ifill_resp_o.valid && !ifill_resp_o.inv.valid) begin
         fill_cnt++;
         fill_data = ifill_resp_o.data;
      end
      if (ifill_resp_o.valid && ifill_resp_o.inv.valid) begin
         inv_q.push_back(ifill_resp_o.inv.paddr);
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
         memreq_cnt++;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Act as the memory: wait for the request, optionally stall it, then return four beats.
   task automatic serve_mem(input logic [39:0] exp_addr, input int stall, input int gap,
                            input logic [31:0] b0, input logic inv_en, input logic [39:0] inv_pa);
      int           t = 0;
      logic [127:0] exp_line = '0;
      while (mem_req_valid_o !== 1'b1 && t < 20) begin
         step();
         t++;
      end
      check("mem_req_valid", mem_req_valid_o, 1'b1);
      check("mem_req_addr", mem_req_addr_o, exp_addr);
      for (int i = 0; i < stall; i++) begin
         mem_resp_valid_i = 1'b1;
         mem_resp_data_i  = 32'hDEADBEEF;
         step();
         check("mem_req_held", {mem_req_valid_o, mem_req_addr_o}, {1'b1, exp_addr});
      end
      mem_resp_valid_i = 1'b0;
      mem_req_ready_i  = 1'b1;
      step();
      mem_req_ready_i  = 1'b0;
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < gap; g++) step();
         mem_resp_valid_i = 1'b1;
         mem_resp_data_i  = b0 * (b + 1);
         exp_line[b*32 +: 32] = b0 * (b + 1);
         if (inv_en && b == 1) begin
            inv_valid_i = 1'b1;
            inv_paddr_i = inv_pa;
         end
         step();
         mem_resp_valid_i = 1'b0;
         inv_valid_i      = 1'b0;
      end
      check("fill_resp_valid", ifill_resp_o.valid, 1'b1);
      check("fill_resp_inv_valid", ifill_resp_o.inv.valid, 1'b0);
      check("fill_resp_data", ifill_resp_o.data, exp_line);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rstn_i           = 1'b0;
      ifill_req_i      = '0;
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
      inv_valid_i      = 1'b0;
      inv_paddr_i      = '0;
      repeat (3) @(posedge clk_i);
      #1;

      // Reset state
      check("rst_resp_valid", ifill_resp_o.valid, 1'b0);
      check("rst_inv_valid", ifill_resp_o.inv.valid, 1'b0);
      check("rst_resp_data", ifill_resp_o.data, '0);
      check("rst_mem_req_valid", mem_req_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_inv_ready", inv_ready_o, 1'b1);
      rstn_i = 1'b1;
      step();

      // Single fill, request pulsed for one cycle
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h80001234;
      ifill_req_i.way   = 2'd1;
      check("idle_no_memreq", mem_req_valid_o, 1'b0);
      step();
      ifill_req_i.valid = 1'b0;
      check("req_latency", mem_req_valid_o, 1'b1);
      check("busy_in_fill", busy_o, 1'b1);
      serve_mem(40'h80001230, 0, 0, 32'h11111111, 1'b0, '0);
      check("fill1_data", ifill_resp_o.data, 128'h44444444_33333333_22222222_11111111);
      step();
      check("fill1_resp_one_cycle", ifill_resp_o.valid, 1'b0);
      check("fill1_idle", busy_o, 1'b0);
      check("fill1_count", fill_cnt, 1);
      check("fill1_memreqs", memreq_cnt, 1);
      repeat (3) step();
      check("fill1_no_refill", memreq_cnt, 1);

      // Backpressure on the request and gaps between beats
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h8000456C;
      step();
      ifill_req_i.valid = 1'b0;
      serve_mem(40'h80004560, 5, 2, 32'h01010101, 1'b0, '0);
      check("fill2_data", ifill_resp_o.data, 128'h04040404_03030303_02020202_01010101);
      repeat (2) step();
      check("fill2_count", fill_cnt, 2);
      check("fill2_memreqs", memreq_cnt, 2);

      // Invalidation arriving during MEM_DATA
      inv_q.delete();
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h80003004;
      step();
      ifill_req_i.valid = 1'b0;
      serve_mem(40'h80003000, 0, 1, 32'h0A0A0A0A, 1'b1, 40'h80002000);
      check("inv_after_fill", inv_q.size(), 0);
      step();
      check("inv_resp_valid", ifill_resp_o.valid, 1'b1);
      check("inv_resp_inv_valid", ifill_resp_o.inv.valid, 1'b1);
      check("inv_resp_paddr", ifill_resp_o.inv.paddr, 40'h80002000);
      step();
      check("inv_resp_one_cycle", ifill_resp_o.valid, 1'b0);
      check("inv_resp_count", inv_q.size(), 1);
      inv_q.delete();

      // FIFO overflow while stalled in MEM_REQ
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h80005000;
      step();
      ifill_req_i.valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         inv_valid_i = 1'b1;
         inv_paddr_i = 40'h80010000 + 40'(k * 64);
         check("fifo_ready_before_push", inv_ready_o, (k < 4) ? 1'b1 : 1'b0);
         step();
      end
      inv_valid_i = 1'b0;
      check("fifo_full_ready", inv_ready_o, 1'b0);
      check("fifo_busy_stalled", busy_o, 1'b1);
      serve_mem(40'h80005000, 0, 0, 32'h05050505, 1'b0, '0);
      check("fifo_no_inv_during_fill", inv_q.size(), 0);
      repeat (6) step();
      check("fifo_inv_count", inv_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < inv_q.size()) begin
            check("fifo_inv_order", inv_q[k], 40'h80010000 + 40'(k * 64));
         end
      end
      check("fifo_drained_ready", inv_ready_o, 1'b1);
      check("fifo_fill_count", fill_cnt, 4);
      inv_q.delete();

      // Request held high for 20 cycles while the memory stalls
      prev_fill   = fill_cnt;
      prev_memreq = memreq_cnt;
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h80008008;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 19) begin
            check("held_req_memreq_valid", mem_req_valid_o, 1'b1);
         end
      end
      ifill_req_i.valid = 1'b0;
      serve_mem(40'h80008000, 0, 0, 32'h06060606, 1'b0, '0);
      repeat (3) step();
      check("held_memreqs", memreq_cnt, prev_memreq + 1);
      check("held_fills", fill_cnt, prev_fill + 1);
      check("held_idle", busy_o, 1'b0);

      // Reset after two beats of a fill
      prev_fill = fill_cnt;
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h80006000;
      step();
      ifill_req_i.valid = 1'b0;
      mem_req_ready_i = 1'b1;
      step();
      mem_req_ready_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_resp_valid_i = 1'b1;
         mem_resp_data_i  = 32'hCAFE0000 + 32'(b);
         step();
      end
      mem_resp_valid_i = 1'b0;
      rstn_i = 1'b0;
      #1;
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_mem_req_valid", mem_req_valid_o, 1'b0);
      check("midrst_resp_valid", ifill_resp_o.valid, 1'b0);
      check("midrst_inv_ready", inv_ready_o, 1'b1);
      check("midrst_resp_data", ifill_resp_o.data, '0);
      step();
      rstn_i = 1'b1;
      repeat (6) step();
      check("midrst_no_resp", fill_cnt, prev_fill);
      check("midrst_idle", busy_o, 1'b0);
      ifill_req_i.valid = 1'b1;
      ifill_req_i.paddr = 40'h80007018;
      step();
      ifill_req_i.valid = 1'b0;
      serve_mem(40'h80007010, 0, 0, 32'h07070707, 1'b0, '0);
      check("postrst_data", ifill_resp_o.data, 128'h1C1C1C1C_15151515_0E0E0E0E_07070707);
      step();
      check("postrst_fills", fill_cnt, prev_fill + 1);
      check("postrst_idle", busy_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
